// File: rtl/imem_ctrl_if.sv
// imem_ctrl_if: fetch, loader and status signals between the PC stage/loader and imem_ctrl
interface imem_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W+1:0] fetch_pc;
  logic              fetch_ready;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_code;
  logic [ADDR_W+1:0] inst_pc;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ack;
  logic              busy;
  logic              misalign;
  modport master (
    output fetch_req, fetch_pc, ld_en, ld_addr, ld_data,
    input  fetch_ready, inst_valid, inst_code, inst_pc, ld_ack, busy, misalign
  );
  modport slave (
    input  fetch_req, fetch_pc, ld_en, ld_addr, ld_data,
    output fetch_ready, inst_valid, inst_code, inst_pc, ld_ack, busy, misalign
  );
endinterface

// File: rtl/imem_ctrl.sv
// imem_ctrl: self-clearing instruction memory with loader port and registered fetch path.
// Define IM_ALIGN_CHK_EN to fault fetches whose byte address is not word aligned.
module imem_ctrl #(
  parameter int              ADDR_W    = 6,
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input logic        clk_im,
  input logic        rst_im,
  imem_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_busy;
  logic              r_inst_valid;
  logic [DATA_W-1:0] r_inst_code;
  logic [ADDR_W+1:0] r_inst_pc;
  logic              r_ld_ack;
  logic              r_misalign;
  logic              w_run;
  logic              w_fire;
  logic              w_we;
  logic              w_mis;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_idx;
  logic [DATA_W-1:0] w_wdata;
  assign w_run           = r_state == RUN;
  assign bus.fetch_ready = w_run && !bus.ld_en;
  assign w_fire          = bus.fetch_req && bus.fetch_ready;
  // the single write port is shared by the clear sweep and the loader
  assign w_we            = !rst_im && (!w_run || bus.ld_en);
  assign w_waddr         = w_run ? bus.ld_addr : r_clr_cnt;
  assign w_wdata         = w_run ? bus.ld_data : FILL_WORD;
  assign w_idx           = bus.fetch_pc[ADDR_W+1:2];
`ifdef IM_ALIGN_CHK_EN
  assign w_mis = bus.fetch_pc[1:0] != 2'b00;
`else
  assign w_mis = 1'b0;
`endif
  assign bus.busy       = r_busy;
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst_code  = r_inst_code;
  assign bus.inst_pc    = r_inst_pc;
  assign bus.ld_ack     = r_ld_ack;
  assign bus.misalign   = r_misalign;
  always_ff @(posedge clk_im)
    if (w_we) r_mem[w_waddr] <= w_wdata;
  always_ff @(posedge clk_im) begin
    if (rst_im) begin
      r_state      <= CLEAR;
      r_clr_cnt    <= '0;
      r_busy       <= 1'b1;
      r_inst_valid <= 1'b0;
      r_inst_code  <= FILL_WORD;
      r_inst_pc    <= '0;
      r_ld_ack     <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_ld_ack     <= w_run && bus.ld_en;
      r_inst_valid <= w_fire;
      r_misalign   <= w_fire && w_mis;
      if (w_fire) begin
        r_inst_code <= w_mis ? FILL_WORD : r_mem[w_idx];
        r_inst_pc   <= bus.fetch_pc;
      end
      if (!w_run) begin
        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
        if (r_clr_cnt == '1) begin
          r_state <= RUN;
          r_busy  <= 1'b0;
        end
      end
    end
  end
endmodule
